// File: rtl/scaler_stream_monitor_pkg.sv
// Shared state encoding and default widths for the scaler stream monitor.
package scaler_stream_monitor_pkg;

  localparam int unsigned DEF_DATA_WIDTH      = 24;
  localparam int unsigned DEF_INPUT_RES_WIDTH = 11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_DONE    = 2'd3
  } mon_state_t;

endpackage

// File: rtl/stream_edge_det.sv
// Registers one strobe and flags its rising edge in the current cycle.
module stream_edge_det (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_strobe,
  output logic o_rise_c
);

  logic r_strobe_d;

  // Delayed copy of the strobe; cleared by synchronous reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_strobe_d <= 1'b0;
    else          r_strobe_d <= i_strobe;
  end

  assign o_rise_c = i_strobe & ~r_strobe_d;

endmodule

// File: rtl/scaler_stream_monitor.sv
// Sink-side checker for the scaler output stream: frame geometry, checksum and
// error counters. Optional pixel sequence check enabled by SCALER_MON_SEQ_CHECK_EN.
module scaler_stream_monitor
  import scaler_stream_monitor_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int unsigned INPUT_RES_WIDTH = DEF_INPUT_RES_WIDTH,
  parameter int unsigned ERR_CNT_WIDTH   = 8,
  parameter int unsigned FRAME_CNT_WIDTH = 16
) (
  input  logic                       clkb,
  input  logic                       rst,
  input  logic                       en,
  input  logic [DATA_WIDTH-1:0]      dIn,
  input  logic                       dInEn,
  input  logic                       iHsyn,
  input  logic                       iVsyn,
  input  logic [INPUT_RES_WIDTH-1:0] expXRes,
  input  logic [INPUT_RES_WIDTH-1:0] expYRes,
  output logic                       frameDone,
  output logic [FRAME_CNT_WIDTH-1:0] frameCnt,
  output logic [INPUT_RES_WIDTH-1:0] rowCnt,
  output logic [INPUT_RES_WIDTH-1:0] lastRowPix,
  output logic [DATA_WIDTH-1:0]      chkSum,
  output logic [ERR_CNT_WIDTH-1:0]   xErrCnt,
  output logic                       yErr,
  output logic [ERR_CNT_WIDTH-1:0]   seqErrCnt
);

  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned RW = INPUT_RES_WIDTH;
  localparam int unsigned EW = ERR_CNT_WIDTH;
  localparam int unsigned FW = FRAME_CNT_WIDTH;

  mon_state_t    r_state, w_state_next;
  logic          w_hs_rise, w_vs_rise;
  logic          w_run, w_pix_valid, w_row_close, w_frame_end, w_clear;
  logic [RW-1:0] r_pix_cnt, r_row_acc, r_row_pix;
  logic [RW-1:0] w_row_pix, w_row_acc_inc, w_rows_final, w_last_final;
  logic [DW-1:0] r_sum_acc;

  logic          r_frame_done, r_yerr;
  logic [FW-1:0] r_frame_cnt;
  logic [RW-1:0] r_row_cnt_pub, r_last_pix_pub;
  logic [DW-1:0] r_chk_sum;
  logic [EW-1:0] r_xerr;

  stream_edge_det u_hs_edge (
    .i_clk   (clkb),
    .i_rst_n (rst),
    .i_strobe(iHsyn),
    .o_rise_c(w_hs_rise)
  );

  stream_edge_det u_vs_edge (
    .i_clk   (clkb),
    .i_rst_n (rst),
    .i_strobe(iVsyn),
    .o_rise_c(w_vs_rise)
  );

  // State register.
  always_ff @(posedge clkb) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_next;
  end

  // Next state plus row-close / frame-end decode for the current cycle.
  always_comb begin
    w_state_next  = r_state;
    w_run         = en & (r_state == ST_ACTIVE);
    w_pix_valid   = w_run & dInEn & ~iVsyn;
    w_row_pix     = r_pix_cnt;
    if (w_pix_valid && !(&r_pix_cnt)) w_row_pix = r_pix_cnt + RW'(1);
    w_row_close   = w_run & (w_hs_rise | w_vs_rise) & (w_row_pix != '0);
    w_row_acc_inc = (&r_row_acc) ? r_row_acc : r_row_acc + RW'(1);
    w_rows_final  = w_row_close ? w_row_acc_inc : r_row_acc;
    w_last_final  = w_row_close ? w_row_pix : r_row_pix;
    w_frame_end   = w_run & w_vs_rise;
    w_clear       = en & (((r_state == ST_WAIT_VS) & w_vs_rise) | (r_state == ST_DONE));
    case (r_state)
      ST_IDLE:    w_state_next = ST_WAIT_VS;
      ST_WAIT_VS: if (w_vs_rise) w_state_next = ST_ACTIVE;
      ST_ACTIVE:  if (w_vs_rise) w_state_next = ST_DONE;
      ST_DONE:    w_state_next = ST_ACTIVE;
      default:    w_state_next = ST_IDLE;
    endcase
    if (!en) w_state_next = ST_IDLE;
  end

  // Working counters for the frame in progress.
  always_ff @(posedge clkb) begin
    if (!rst) begin
      r_pix_cnt <= '0;
      r_row_acc <= '0;
      r_row_pix <= '0;
      r_sum_acc <= '0;
    end else if (w_clear) begin
      r_pix_cnt <= '0;
      r_row_acc <= '0;
      r_row_pix <= '0;
      r_sum_acc <= '0;
    end else if (w_run) begin
      if (w_pix_valid) r_sum_acc <= r_sum_acc + dIn;
      if (w_row_close) begin
        r_pix_cnt <= '0;
        r_row_acc <= w_row_acc_inc;
        r_row_pix <= w_row_pix;
      end else begin
        r_pix_cnt <= w_row_pix;
      end
    end
  end

  // Published results, frame pulse and cumulative row-width errors.
  always_ff @(posedge clkb) begin
    if (!rst) begin
      r_frame_done   <= 1'b0;
      r_frame_cnt    <= '0;
      r_row_cnt_pub  <= '0;
      r_last_pix_pub <= '0;
      r_chk_sum      <= '0;
      r_yerr         <= 1'b0;
      r_xerr         <= '0;
    end else begin
      r_frame_done <= w_frame_end;
      if (w_row_close && (w_row_pix != expXRes) && !(&r_xerr)) r_xerr <= r_xerr + EW'(1);
      if (w_frame_end) begin
        r_row_cnt_pub  <= w_rows_final;
        r_last_pix_pub <= w_last_final;
        r_chk_sum      <= r_sum_acc;
        r_yerr         <= (w_rows_final != expYRes);
        r_frame_cnt    <= r_frame_cnt + FW'(1);
      end
    end
  end

`ifdef SCALER_MON_SEQ_CHECK_EN
  logic          r_seq_armed;
  logic [DW-1:0] r_seq_exp;
  logic [EW-1:0] r_seq_err;

  // Each counted pixel after the first of a frame must be previous + 1.
  always_ff @(posedge clkb) begin
    if (!rst) begin
      r_seq_armed <= 1'b0;
      r_seq_exp   <= '0;
      r_seq_err   <= '0;
    end else if (w_clear) begin
      r_seq_armed <= 1'b0;
    end else if (w_pix_valid) begin
      r_seq_armed <= 1'b1;
      r_seq_exp   <= dIn + DW'(1);
      if (r_seq_armed && (dIn != r_seq_exp) && !(&r_seq_err)) r_seq_err <= r_seq_err + EW'(1);
    end
  end

  assign seqErrCnt = r_seq_err;
`else
  assign seqErrCnt = '0;
`endif

  assign frameDone  = r_frame_done;
  assign frameCnt   = r_frame_cnt;
  assign rowCnt     = r_row_cnt_pub;
  assign lastRowPix = r_last_pix_pub;
  assign chkSum     = r_chk_sum;
  assign xErrCnt    = r_xerr;
  assign yErr       = r_yerr;

endmodule

// File: tb/tb_scaler_stream_monitor.sv
// Bench for scaler_stream_monitor: directed frames plus randomized frames checked
// against a frame-level reference model. Honors SCALER_MON_SEQ_CHECK_EN.
module tb_scaler_stream_monitor;

  logic        clkb;
  logic        rst, en, dInEn, iHsyn, iVsyn;
  logic [23:0] dIn;
  logic [10:0] expXRes, expYRes;
  logic        frameDone, yErr;
  logic [15:0] frameCnt;
  logic [10:0] rowCnt, lastRowPix;
  logic [23:0] chkSum;
  logic [7:0]  xErrCnt, seqErrCnt;

  scaler_stream_monitor dut (
    .clkb(clkb), .rst(rst), .en(en), .dIn(dIn), .dInEn(dInEn),
    .iHsyn(iHsyn), .iVsyn(iVsyn), .expXRes(expXRes), .expYRes(expYRes),
    .frameDone(frameDone), .frameCnt(frameCnt), .rowCnt(rowCnt),
    .lastRowPix(lastRowPix), .chkSum(chkSum), .xErrCnt(xErrCnt),
    .yErr(yErr), .seqErrCnt(seqErrCnt)
  );

  initial begin
    clkb = 1'b0;
    forever #5 clkb = ~clkb;
  end

  int n_vec = 0;
  int n_err = 0;

  // Bench-side settings applied together with the next driven cycle.
  bit          b_en   = 1'b0;
  int          b_expx = 6;
  int          b_expy = 6;
  logic [23:0] g_data = 24'd1;

  // Reference model: frame phase 0 off, 1 waiting for VS, 2 in frame, 3 frame just ended.
  int          m_mode = 0;
  bit          m_hs_prev = 1'b0, m_vs_prev = 1'b0;
  int          m_pix = 0, m_rows = 0, m_last = 0;
  logic [23:0] m_sum = 24'd0;
  bit          m_armed = 1'b0;
  logic [23:0] m_prev = 24'd0;
  int          m_xerr = 0, m_seqerr = 0, m_frame_cnt = 0;
  bit          m_exp_done = 1'b0;
  int          m_pub_rows = 0, m_pub_last = 0;
  logic [23:0] m_pub_sum = 24'd0;
  bit          m_pub_yerr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_hs_prev = 1'b0; m_vs_prev = 1'b0;
    m_pix = 0; m_rows = 0; m_last = 0; m_sum = 24'd0; m_armed = 1'b0; m_prev = 24'd0;
    m_xerr = 0; m_seqerr = 0; m_frame_cnt = 0; m_exp_done = 1'b0;
    m_pub_rows = 0; m_pub_last = 0; m_pub_sum = 24'd0; m_pub_yerr = 1'b0;
  endtask

  task automatic frame_clear();
    m_pix = 0; m_rows = 0; m_last = 0; m_sum = 24'd0; m_armed = 1'b0;
  endtask

  task automatic model_step(input bit hs, input bit vs, input bit den, input logic [23:0] d);
    bit hs_r, vs_r;
    hs_r = hs && !m_hs_prev;
    vs_r = vs && !m_vs_prev;
    m_hs_prev = hs;
    m_vs_prev = vs;
    if (!b_en) begin
      m_mode = 0;
      return;
    end
    case (m_mode)
      0: m_mode = 1;
      1: if (vs_r) begin frame_clear(); m_mode = 2; end
      3: begin frame_clear(); m_mode = 2; end
      default: begin
        if (den && !vs) begin
          if (m_pix < 2047) m_pix++;
          m_sum = m_sum + d;
`ifdef SCALER_MON_SEQ_CHECK_EN
          if (m_armed && d != m_prev + 24'd1 && m_seqerr < 255) m_seqerr++;
`endif
          m_prev = d;
          m_armed = 1'b1;
        end
        if ((hs_r || vs_r) && m_pix > 0) begin
          if (m_rows < 2047) m_rows++;
          m_last = m_pix;
          if (m_pix != b_expx && m_xerr < 255) m_xerr++;
          m_pix = 0;
        end
        if (vs_r) begin
          m_exp_done  = 1'b1;
          m_pub_rows  = m_rows;
          m_pub_last  = m_last;
          m_pub_sum   = m_sum;
          m_pub_yerr  = (m_rows != b_expy);
          m_frame_cnt = (m_frame_cnt + 1) & 32'hFFFF;
          m_mode      = 3;
        end
      end
    endcase
  endtask

  // One cycle: compare every output with the model, away from the rising edge.
  task automatic tick();
    @(negedge clkb);
    chk("frameDone",  32'(frameDone),  32'(m_exp_done));
    chk("frameCnt",   32'(frameCnt),   32'(m_frame_cnt));
    chk("rowCnt",     32'(rowCnt),     32'(m_pub_rows));
    chk("lastRowPix", 32'(lastRowPix), 32'(m_pub_last));
    chk("chkSum",     32'(chkSum),     32'(m_pub_sum));
    chk("xErrCnt",    32'(xErrCnt),    32'(m_xerr));
    chk("yErr",       32'(yErr),       32'(m_pub_yerr));
    chk("seqErrCnt",  32'(seqErrCnt),  32'(m_seqerr));
    m_exp_done = 1'b0;
  endtask

  task automatic drive(input bit hs, input bit vs, input bit den, input logic [23:0] d);
    tick();
    rst = 1'b1; en = b_en; expXRes = 11'(b_expx); expYRes = 11'(b_expy);
    iHsyn = hs; iVsyn = vs; dInEn = den; dIn = d;
    model_step(hs, vs, den, d);
  endtask

  task automatic pulse_reset();
    tick();
    rst = 1'b0; en = b_en; iHsyn = 1'b0; iVsyn = 1'b0; dInEn = 1'b0;
    model_reset();
  endtask

  // A row of n pixels from g_data, closed by an HS (optionally on the last pixel).
  task automatic send_row(input int n, input bit hs_last, input bit gaps,
                          input bit jumpy, input logic [23:0] skip);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) drive(1'b0, 1'b0, 1'b0, 24'd0);
      if (jumpy && $urandom_range(0, 7) == 0) g_data = 24'($urandom);
      if (skip != 24'd0 && g_data == skip) g_data = g_data + 24'd1;
      drive(hs_last && (i == n - 1), 1'b0, 1'b1, g_data);
      g_data = g_data + 24'd1;
    end
    if (!(hs_last && n > 0)) drive(1'b1, 1'b0, 1'b0, 24'd0);
    drive(1'b0, 1'b0, 1'b0, 24'd0);
  endtask

  task automatic send_vs(input int hold, input bit junk);
    for (int i = 0; i < hold; i++)
      drive(1'b0, 1'b1, junk && ($urandom_range(0, 1) == 1), 24'($urandom));
    drive(1'b0, 1'b0, 1'b0, 24'd0);
  endtask

  task automatic std_frame(input int rows, input int short_idx, input logic [23:0] skip);
    g_data = 24'd1;
    for (int r = 0; r < rows; r++) send_row((r == short_idx) ? 5 : 6, 1'b0, 1'b0, 1'b0, skip);
    send_vs(2, 1'b0);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; dIn = '0; dInEn = 1'b0; iHsyn = 1'b0; iVsyn = 1'b0;
    expXRes = 11'd6; expYRes = 11'd6;
    pulse_reset();
    tick();
    chk("rst_frameCnt", 32'(frameCnt), 32'd0);
    chk("rst_chkSum",   32'(chkSum),   32'd0);

    // Stream starts mid-frame: two rows before the first VS are ignored.
    b_en = 1'b1; b_expx = 6; b_expy = 6;
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 24'd0);
    g_data = 24'd50;
    send_row(6, 1'b0, 1'b0, 1'b0, 24'd0);
    send_row(6, 1'b0, 1'b0, 1'b0, 24'd0);
    send_vs(2, 1'b0);
    chk("midstart_frameCnt", 32'(frameCnt), 32'd0);

    // Nominal frame.
    std_frame(6, -1, 24'd0);
    chk("nom_frameCnt", 32'(frameCnt),   32'd1);
    chk("nom_rowCnt",   32'(rowCnt),     32'd6);
    chk("nom_lastPix",  32'(lastRowPix), 32'd6);
    chk("nom_chkSum",   32'(chkSum),     32'd666);
    chk("nom_xErr",     32'(xErrCnt),    32'd0);
    chk("nom_yErr",     32'(yErr),       32'd0);

    // Short third row.
    std_frame(6, 2, 24'd0);
    chk("short_xErr",   32'(xErrCnt), 32'd1);
    chk("short_chkSum", 32'(chkSum),  32'd630);
    chk("short_rowCnt", 32'(rowCnt),  32'd6);
    chk("short_yErr",   32'(yErr),    32'd0);

    // Missing row.
    std_frame(5, -1, 24'd0);
    chk("miss_rowCnt", 32'(rowCnt),  32'd5);
    chk("miss_yErr",   32'(yErr),    32'd1);
    chk("miss_chkSum", 32'(chkSum),  32'd465);
    chk("miss_xErr",   32'(xErrCnt), 32'd1);

    // Data skips 10 -> 12.
    std_frame(6, -1, 24'd11);
    chk("skip_chkSum", 32'(chkSum), 32'd692);
`ifdef SCALER_MON_SEQ_CHECK_EN
    chk("skip_seqErr", 32'(seqErrCnt), 32'd1);
`else
    chk("skip_seqErr", 32'(seqErrCnt), 32'd0);
`endif

    // Randomized frames: empty HS rows, gaps, pixel on HS, data jumps, VS junk.
    for (int f = 0; f < 25; f++) begin
      int rows;
      b_expy = $urandom_range(0, 8);
      rows   = $urandom_range(0, 8);
      for (int r = 0; r < rows; r++) begin
        if ($urandom_range(0, 3) == 0) b_expx = $urandom_range(0, 9);
        send_row($urandom_range(0, 9), 1'($urandom_range(0, 1)), 1'b1, 1'b1, 24'd0);
      end
      send_vs($urandom_range(1, 3), 1'b1);
    end

    // Saturation: 260 one-pixel rows then an over-long row closed by VS.
    b_expx = 6; b_expy = 6; g_data = 24'd1;
    for (int r = 0; r < 260; r++) send_row(1, 1'b1, 1'b0, 1'b0, 24'd0);
    for (int i = 0; i < 2100; i++) begin
      drive(1'b0, 1'b0, 1'b1, g_data);
      g_data = g_data + 24'd1;
    end
    send_vs(2, 1'b0);
    chk("sat_lastPix", 32'(lastRowPix), 32'd2047);
    chk("sat_xErr",    32'(xErrCnt),    32'd255);
    chk("sat_rowCnt",  32'(rowCnt),     32'd261);
    chk("sat_yErr",    32'(yErr),       32'd1);

    // Reset during row 2 discards the partial frame.
    g_data = 24'd1;
    send_row(6, 1'b0, 1'b0, 1'b0, 24'd0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 24'(i + 7));
    pulse_reset();
    tick();
    chk("mrst_frameCnt", 32'(frameCnt),   32'd0);
    chk("mrst_rowCnt",   32'(rowCnt),     32'd0);
    chk("mrst_lastPix",  32'(lastRowPix), 32'd0);
    chk("mrst_chkSum",   32'(chkSum),     32'd0);
    chk("mrst_xErr",     32'(xErrCnt),    32'd0);
    chk("mrst_seqErr",   32'(seqErrCnt),  32'd0);
    send_row(3, 1'b0, 1'b0, 1'b0, 24'd0);
    send_vs(2, 1'b0);
    chk("mrst_vs1_frameCnt", 32'(frameCnt), 32'd0);
    std_frame(6, -1, 24'd0);
    chk("mrst_frameCnt2", 32'(frameCnt), 32'd1);
    chk("mrst_chkSum2",   32'(chkSum),   32'd666);
    chk("mrst_rowCnt2",   32'(rowCnt),   32'd6);

    // Disabled monitor: results hold, no frame pulse.
    b_en = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 24'd0);
    std_frame(4, -1, 24'd0);
    tick();
    chk("dis_frameCnt", 32'(frameCnt), 32'd1);
    chk("dis_chkSum",   32'(chkSum),   32'd666);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
